// File: rtl/menshen_ram_pkg.sv
// Shared types and helpers for the Menshen lookup-table RAM.
// Optional parity storage is enabled by defining MENSHEN_RAM_PARITY_EN.
package menshen_ram_pkg;

    localparam int unsigned MAX_READ_LATENCY = 3;

    typedef enum logic {
        ST_CLEAR,
        ST_RUN
    } ram_state_e;

    function automatic int unsigned ram_depth(input int unsigned addr_bits);
        return 32'd1 << addr_bits;
    endfunction

endpackage

// File: rtl/lkup_ram_core.sv
// Bare simple-dual-port storage with a 1-cycle registered read port.
// Read-before-write on same-address collision; no reset so block RAM is inferred.
module lkup_ram_core
    import menshen_ram_pkg::*;
#(
    parameter int unsigned ADDR_BITS = 4,
    parameter int unsigned WIDTH     = 625
) (
    input  logic                 clk_i,
    input  logic                 we_i,
    input  logic [ADDR_BITS-1:0] waddr_i,
    input  logic [WIDTH-1:0]     wdata_i,
    input  logic                 re_i,
    input  logic [ADDR_BITS-1:0] raddr_i,
    output logic [WIDTH-1:0]     rdata_o
);

    localparam int unsigned DEPTH = ram_depth(ADDR_BITS);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/menshen_lkup_ram.sv
// Lookup-table RAM: clear-after-reset walker, collision bypass and read latency pipeline.
// Define MENSHEN_RAM_PARITY_EN to store an even-parity bit and expose parity_err.
module menshen_lkup_ram
    import menshen_ram_pkg::*;
#(
    parameter int unsigned ADDR_BITS    = 4,
    parameter int unsigned DATA_BITS    = 625,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned WRITE_FIRST  = 1,
    parameter int unsigned INIT_CLEAR   = 1
) (
    input  logic                 clk,
    input  logic                 aresetn,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [DATA_BITS-1:0] wr_data,
    input  logic                 rd_en,
    input  logic [ADDR_BITS-1:0] rd_addr,
    output logic [DATA_BITS-1:0] rd_data,
    output logic                 rd_valid,
    output logic                 init_busy
`ifdef MENSHEN_RAM_PARITY_EN
    ,
    output logic                 parity_err
`endif
);

    localparam int unsigned DEPTH = ram_depth(ADDR_BITS);
`ifdef MENSHEN_RAM_PARITY_EN
    localparam int unsigned SW = DATA_BITS + 1;
`else
    localparam int unsigned SW = DATA_BITS;
`endif

    if (READ_LATENCY < 1 || READ_LATENCY > MAX_READ_LATENCY) begin : g_bad_latency
        $error("READ_LATENCY must be in 1..%0d", MAX_READ_LATENCY);
    end

    ram_state_e           state_q, state_d;
    logic [ADDR_BITS-1:0] walk_q, walk_d;
    logic                 busy_q, busy_d;

    always_comb begin
        state_d = state_q;
        walk_d  = walk_q;
        if (state_q == ST_CLEAR) begin
            if (walk_q == ADDR_BITS'(DEPTH - 1)) begin
                state_d = ST_RUN;
            end else begin
                walk_d = walk_q + 1'b1;
            end
        end
        busy_d = (state_d == ST_CLEAR);
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= (INIT_CLEAR != 0) ? ST_CLEAR : ST_RUN;
            walk_q  <= '0;
            busy_q  <= (INIT_CLEAR != 0);
        end else begin
            state_q <= state_d;
            walk_q  <= walk_d;
            busy_q  <= busy_d;
        end
    end

    assign init_busy = busy_q;

    logic          wr_acc, rd_acc, collide;
    logic [SW-1:0] wr_word, core_wdata, core_rdata;

    assign wr_acc  = wr_en & ~busy_q;
    assign rd_acc  = rd_en & ~busy_q;
    assign collide = rd_acc & wr_acc & (rd_addr == wr_addr) & (WRITE_FIRST != 0);
`ifdef MENSHEN_RAM_PARITY_EN
    assign wr_word = {^wr_data, wr_data};
`else
    assign wr_word = wr_data;
`endif
    assign core_wdata = busy_q ? '0 : wr_word;

    lkup_ram_core #(
        .ADDR_BITS (ADDR_BITS),
        .WIDTH     (SW)
    ) u_core (
        .clk_i   (clk),
        .we_i    (busy_q | wr_acc),
        .waddr_i (busy_q ? walk_q : wr_addr),
        .wdata_i (core_wdata),
        .re_i    (rd_acc),
        .raddr_i (rd_addr),
        .rdata_o (core_rdata)
    );

    // Bypass state only changes on an accepted read, so stage-0 data holds between reads.
    logic          byp_q, byp_d;
    logic [SW-1:0] byp_word_q, byp_word_d;

    always_comb begin
        byp_d      = rd_acc ? collide : byp_q;
        byp_word_d = collide ? wr_word : byp_word_q;
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            byp_q <= 1'b0;
        end else begin
            byp_q <= byp_d;
        end
    end

    always_ff @(posedge clk) begin
        byp_word_q <= byp_word_d;
    end

    logic [SW-1:0]        s0_word;
    logic [DATA_BITS-1:0] s0_data;

    assign s0_word = byp_q ? byp_word_q : core_rdata;
    assign s0_data = s0_word[DATA_BITS-1:0];
`ifdef MENSHEN_RAM_PARITY_EN
    logic s0_err;
    assign s0_err = ^s0_word;
`endif

    logic [READ_LATENCY-1:0] vld_q, vld_d;

    always_comb begin
        vld_d    = vld_q << 1;
        vld_d[0] = rd_acc;
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            vld_q <= '0;
        end else begin
            vld_q <= vld_d;
        end
    end

    assign rd_valid = vld_q[READ_LATENCY-1];

    if (READ_LATENCY == 1) begin : g_lat1
        // Masks the unreset core register until the first read after reset.
        logic seen_q, seen_d;
        assign seen_d = seen_q | rd_acc;

        always_ff @(posedge clk or negedge aresetn) begin
            if (!aresetn) begin
                seen_q <= 1'b0;
            end else begin
                seen_q <= seen_d;
            end
        end

        assign rd_data = seen_q ? s0_data : '0;
`ifdef MENSHEN_RAM_PARITY_EN
        assign parity_err = vld_q[0] & s0_err;
`endif
    end else begin : g_latn
        logic [DATA_BITS-1:0] dat_q [READ_LATENCY-1];
        logic [DATA_BITS-1:0] dat_d [READ_LATENCY-1];

        always_comb begin
            dat_d[0] = vld_q[0] ? s0_data : dat_q[0];
            for (int k = 1; k < int'(READ_LATENCY) - 1; k++) begin
                dat_d[k] = vld_q[k] ? dat_q[k-1] : dat_q[k];
            end
        end

        always_ff @(posedge clk or negedge aresetn) begin
            if (!aresetn) begin
                for (int k = 0; k < int'(READ_LATENCY) - 1; k++) begin
                    dat_q[k] <= '0;
                end
            end else begin
                for (int k = 0; k < int'(READ_LATENCY) - 1; k++) begin
                    dat_q[k] <= dat_d[k];
                end
            end
        end

        assign rd_data = dat_q[READ_LATENCY-2];

`ifdef MENSHEN_RAM_PARITY_EN
        logic [READ_LATENCY-2:0] err_q, err_d;

        always_comb begin
            err_d = err_q;
            for (int k = 0; k < int'(READ_LATENCY) - 1; k++) begin
                if (vld_q[k]) begin
                    err_d[k] = (k == 0) ? s0_err : err_q[(k == 0) ? 0 : k - 1];
                end
            end
        end

        always_ff @(posedge clk or negedge aresetn) begin
            if (!aresetn) begin
                err_q <= '0;
            end else begin
                err_q <= err_d;
            end
        end

        assign parity_err = rd_valid & err_q[READ_LATENCY-2];
`endif
    end

endmodule

// File: tb/tb_menshen_lkup_ram.sv
// Scoreboard bench for menshen_lkup_ram: four instances (latency 1/2/3 write-first, latency 1
// read-first) share one stimulus stream; expected reads are queued per instance.
module tb_menshen_lkup_ram;

    localparam int NI    = 4;
    localparam int AW    = 4;
    localparam int DW    = 625;
    localparam int DEPTH = 16;

    function automatic int lat_of(input int i);
        case (i)
            0: return 1;
            1: return 2;
            2: return 3;
            default: return 1;
        endcase
    endfunction

    function automatic int wf_of(input int i);
        return (i == 3) ? 0 : 1;
    endfunction

    logic          clk = 1'b0;
    logic          aresetn = 1'b0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          rd_en = 1'b0;
    logic [AW-1:0] rd_addr = '0;

    logic          rd_valid  [NI];
    logic [DW-1:0] rd_data   [NI];
    logic          init_busy [NI];
`ifdef MENSHEN_RAM_PARITY_EN
    logic          parity_err [NI];
`endif

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        menshen_lkup_ram #(
            .ADDR_BITS    (AW),
            .DATA_BITS    (DW),
            .READ_LATENCY (lat_of(g)),
            .WRITE_FIRST  (wf_of(g)),
            .INIT_CLEAR   (1)
        ) u_dut (
            .clk        (clk),
            .aresetn    (aresetn),
            .wr_en      (wr_en),
            .wr_addr    (wr_addr),
            .wr_data    (wr_data),
            .rd_en      (rd_en),
            .rd_addr    (rd_addr),
            .rd_data    (rd_data[g]),
            .rd_valid   (rd_valid[g]),
            .init_busy  (init_busy[g])
`ifdef MENSHEN_RAM_PARITY_EN
            ,
            .parity_err (parity_err[g])
`endif
        );
    end

    typedef struct {
        logic [DW-1:0] data;
        logic          perr;
        int            due;
    } exp_t;

    exp_t          sb [NI][$];
    logic [DW-1:0] mem_m [DEPTH];
    int            cyc = 0;
    int            busy_cnt = 0;
    int            flip_addr = -1;
    int            n_checks = 0;
    int            n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Every rd_valid must match the queue head, on exactly the cycle it was due.
    always @(negedge clk) begin
        exp_t e;
        if (aresetn) begin
            for (int i = 0; i < NI; i++) begin
                if (rd_valid[i]) begin
                    if (sb[i].size() == 0) begin
                        check($sformatf("unexpected_valid[%0d]", i), 1, 0);
                    end else begin
                        e = sb[i].pop_front();
                        check($sformatf("valid_cycle[%0d]", i), cyc, e.due);
                        check($sformatf("rd_data[%0d]", i), rd_data[i], e.data);
`ifdef MENSHEN_RAM_PARITY_EN
                        check($sformatf("parity_err[%0d]", i), parity_err[i], e.perr);
`endif
                    end
                end else if (sb[i].size() > 0 && sb[i][0].due <= cyc) begin
                    check($sformatf("missing_valid[%0d]", i), 0, 1);
                    void'(sb[i].pop_front());
                end
            end
        end
    end

    task automatic step(input logic we, input int wa, input logic [DW-1:0] wd,
                        input logic re, input int ra);
        logic acc;
        exp_t e;
        acc     = (busy_cnt == 0);
        wr_en   = we;
        wr_addr = AW'(wa);
        wr_data = wd;
        rd_en   = re;
        rd_addr = AW'(ra);
        for (int i = 0; i < NI; i++) begin
            check($sformatf("init_busy[%0d]", i), init_busy[i], !acc);
        end
        if (re && acc) begin
            for (int i = 0; i < NI; i++) begin
                e.data = (we && wa == ra && wf_of(i) != 0) ? wd : mem_m[ra];
                e.perr = (i == 0 && ra == flip_addr);
                e.due  = cyc + lat_of(i);
                sb[i].push_back(e);
            end
        end
        if (we && acc) mem_m[wa] = wd;
        if (!acc) begin
            mem_m[DEPTH - busy_cnt] = '0;
            busy_cnt--;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 0, '0, 1'b0, 0);
    endtask

    task automatic do_reset(input int hold);
        aresetn = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
            sb[i].delete();
            check($sformatf("rst_rd_valid[%0d]", i), rd_valid[i], 0);
            check($sformatf("rst_rd_data[%0d]", i), rd_data[i], '0);
            check($sformatf("rst_init_busy[%0d]", i), init_busy[i], 1);
        end
        for (int k = 0; k < hold; k++) @(posedge clk);
        #1;
        aresetn  = 1'b1;
        busy_cnt = DEPTH;
    endtask

    initial begin
        @(posedge clk);
        #1;
        do_reset(2);

        // Requests held during the clear are dropped.
        for (int k = 0; k < DEPTH; k++) step(1'b1, 7, 'h55, 1'b1, 7);
        for (int a = 0; a < DEPTH; a++) step(1'b0, 0, '0, 1'b1, a);
        idle(4);

        step(1'b1, 3, 'hA5, 1'b0, 0);
        step(1'b0, 0, '0, 1'b1, 3);
        idle(4);
        for (int i = 0; i < NI; i++) begin
            check($sformatf("hold_rd_valid[%0d]", i), rd_valid[i], 0);
            check($sformatf("hold_rd_data[%0d]", i), rd_data[i], 'hA5);
        end

        step(1'b1, 5, 'h7, 1'b0, 0);
        step(1'b1, 5, 'h1, 1'b1, 5);
        step(1'b0, 0, '0, 1'b1, 5);
        idle(4);

        // Write right behind a read must not disturb the in-flight data.
        step(1'b0, 0, '0, 1'b1, 3);
        step(1'b1, 3, 'h3C, 1'b0, 0);
        step(1'b0, 0, '0, 1'b1, 3);
        idle(4);

        for (int a = 0; a < DEPTH; a++) step(1'b1, a, DW'(a), 1'b0, 0);
        for (int a = 0; a < DEPTH; a++) step(1'b0, 0, '0, 1'b1, a);
        idle(5);

`ifdef MENSHEN_RAM_PARITY_EN
        g_dut[0].u_dut.u_core.mem[2][DW] = ~g_dut[0].u_dut.u_core.mem[2][DW];
        flip_addr = 2;
        step(1'b0, 0, '0, 1'b1, 2);
        step(1'b0, 0, '0, 1'b1, 4);
        idle(5);
        flip_addr = -1;
`endif

        step(1'b0, 0, '0, 1'b1, 1);
        do_reset(1);
        idle(5);
        do_reset(1);
        idle(DEPTH);
        for (int a = 0; a < DEPTH; a++) step(1'b0, 0, '0, 1'b1, a);
        idle(5);

        for (int i = 0; i < NI; i++) begin
            check($sformatf("sb_empty[%0d]", i), sb[i].size(), 0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
